// File: rtl/rtranif1_tranif0.sv
// ---------------------------------------------------------------------------
// rtranif1_tranif0
//
// Purpose:
//   Cycle-registered behavioural model of two independent bidirectional
//   switch primitives operating on 4-state values with 8-level strengths:
//     channel 0 : tranif0  (conducts when gate = 0, strength passed as-is)
//     channel 1 : rtranif1 (conducts when gate = 1, strength reduced)
//   Each channel resolves both terminals from their own drive plus the drive
//   propagated through the switch (single hop), and registers the result.
//
// Encodings:
//   value    [1:0] : 00 = 0, 01 = 1, 10 = Z, 11 = X
//   strength [2:0] : 0 highz, 1 small, 2 medium, 3 weak, 4 large,
//                    5 pull, 6 strong, 7 supply
//
// Ports:
//   clk                      in   rising-edge clock for all state
//   rst_n                    in   asynchronous active-low reset
//   t0_gate, t1_gate         in   gate values of channel 0 / channel 1
//   tN_a_val, tN_b_val       in   external drive value on terminal a / b
//   tN_a_str, tN_b_str       in   external drive strength on terminal a / b
//   tN_a_q_val, tN_b_q_val   out  registered resolved value of terminal a / b
//   tN_a_q_str, tN_b_q_str   out  registered resolved strength of a / b
//   tN_on                    out  registered flag: channel N conducts
// ---------------------------------------------------------------------------
module rtranif1_tranif0 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] t0_gate,
  input  logic [1:0] t1_gate,
  input  logic [1:0] t0_a_val,
  input  logic [1:0] t0_b_val,
  input  logic [1:0] t1_a_val,
  input  logic [1:0] t1_b_val,
  input  logic [2:0] t0_a_str,
  input  logic [2:0] t0_b_str,
  input  logic [2:0] t1_a_str,
  input  logic [2:0] t1_b_str,
  output logic [1:0] t0_a_q_val,
  output logic [1:0] t0_b_q_val,
  output logic [1:0] t1_a_q_val,
  output logic [1:0] t1_b_q_val,
  output logic [2:0] t0_a_q_str,
  output logic [2:0] t0_b_q_str,
  output logic [2:0] t1_a_q_str,
  output logic [2:0] t1_b_q_str,
  output logic       t0_on,
  output logic       t1_on
);

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  localparam int NUM_CH = 2;

  // A drive is a (value, strength) pair.
  typedef struct packed {
    logic [1:0] val;
    logic [2:0] str;
  } drive_t;

  localparam drive_t DRV_HIGHZ = '{val: VZ, str: 3'd0};

  // Conduction state of a switch as decided by its gate.
  typedef enum logic [1:0] {
    SW_OPEN = 2'd0,
    SW_ON   = 2'd1,
    SW_UNK  = 2'd2
  } sw_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // A Z value or a zero strength both mean "not driving".
  function automatic drive_t normalise(input drive_t d);
    drive_t r;
    if (d.val == VZ || d.str == 3'd0) r = DRV_HIGHZ;
    else                              r = d;
    return r;
  endfunction

  // Resistive switch strength reduction.
  function automatic logic [2:0] reduce_str(input logic [2:0] s);
    logic [2:0] r;
    case (s)
      3'd7:    r = 3'd5;
      3'd6:    r = 3'd5;
      3'd5:    r = 3'd3;
      3'd4:    r = 3'd2;
      3'd3:    r = 3'd2;
      3'd2:    r = 3'd1;
      3'd1:    r = 3'd1;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  // Gate decoding; on_level selects which gate value closes the switch.
  function automatic sw_t gate_state(input logic [1:0] g, input logic [1:0] on_level);
    sw_t r;
    if (g == VZ || g == VX) r = SW_UNK;
    else if (g == on_level) r = SW_ON;
    else                    r = SW_OPEN;
    return r;
  endfunction

  // Drive seen by the receiving terminal through the switch. Both arguments
  // are already normalised, so a zero strength here always carries Z.
  function automatic drive_t propagate(input drive_t src, input drive_t dst_own,
                                       input sw_t sw, input logic resistive);
    drive_t p;
    p = src;
    if (resistive) p.str = reduce_str(src.str);
    if (sw == SW_OPEN) begin
      p = DRV_HIGHZ;
    end else if (sw == SW_UNK) begin
      // With an undecided switch the receiver can only be sure of the value
      // if it already carries that same value itself.
      if (p.str != 3'd0 && p.val != dst_own.val) p.val = VX;
    end
    return p;
  endfunction

  // Strength-based resolution of a terminal's own drive and propagated drive.
  function automatic drive_t resolve(input drive_t own, input drive_t p);
    drive_t r;
    if (own.str > p.str)       r = own;
    else if (p.str > own.str)  r = p;
    else if (own.str == 3'd0)  r = DRV_HIGHZ;
    else if (own.val == p.val) r = own;
    else                       r = '{val: VX, str: own.str};
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Per-channel input bundling
  // -------------------------------------------------------------------------
  logic [1:0] gate_in  [NUM_CH];
  drive_t     a_in     [NUM_CH];
  drive_t     b_in     [NUM_CH];

  assign gate_in[0] = t0_gate;
  assign gate_in[1] = t1_gate;
  assign a_in[0]    = '{val: t0_a_val, str: t0_a_str};
  assign b_in[0]    = '{val: t0_b_val, str: t0_b_str};
  assign a_in[1]    = '{val: t1_a_val, str: t1_a_str};
  assign b_in[1]    = '{val: t1_b_val, str: t1_b_str};

  // Next-state values for every channel.
  drive_t a_d  [NUM_CH];
  drive_t b_d  [NUM_CH];
  logic   on_d [NUM_CH];

  // -------------------------------------------------------------------------
  // Channel datapath: channel 0 is tranif0, channel 1 is rtranif1.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      localparam logic       RESISTIVE = (gi == 1);
      localparam logic [1:0] ON_LEVEL  = (gi == 1) ? V1 : V0;

      drive_t a_n, b_n;
      drive_t a_p, b_p;
      sw_t    sw;

      assign a_n = normalise(a_in[gi]);
      assign b_n = normalise(b_in[gi]);
      assign sw  = gate_state(gate_in[gi], ON_LEVEL);

      // Single hop: only the terminals' own normalised drives cross the
      // switch, never the resolved results.
      assign a_p = propagate(b_n, a_n, sw, RESISTIVE);
      assign b_p = propagate(a_n, b_n, sw, RESISTIVE);

      assign a_d[gi]  = resolve(a_n, a_p);
      assign b_d[gi]  = resolve(b_n, b_p);
      assign on_d[gi] = (sw == SW_ON);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  drive_t a_q  [NUM_CH];
  drive_t b_q  [NUM_CH];
  logic   on_q [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        a_q[i]  <= DRV_HIGHZ;
        b_q[i]  <= DRV_HIGHZ;
        on_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        a_q[i]  <= a_d[i];
        b_q[i]  <= b_d[i];
        on_q[i] <= on_d[i];
      end
    end
  end

  assign t0_a_q_val = a_q[0].val;
  assign t0_a_q_str = a_q[0].str;
  assign t0_b_q_val = b_q[0].val;
  assign t0_b_q_str = b_q[0].str;
  assign t1_a_q_val = a_q[1].val;
  assign t1_a_q_str = a_q[1].str;
  assign t1_b_q_val = b_q[1].val;
  assign t1_b_q_str = b_q[1].str;
  assign t0_on      = on_q[0];
  assign t1_on      = on_q[1];

endmodule

// File: tb/tb_rtranif1_tranif0.sv
// ---------------------------------------------------------------------------
// tb_rtranif1_tranif0
//
// Directed-vector bench for rtranif1_tranif0. Expected values are worked out
// by hand from the switch rules and written into each step.
// ---------------------------------------------------------------------------
module tb_rtranif1_tranif0;

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  logic       clk;
  logic       rst_n;
  logic [1:0] t0_gate, t1_gate;
  logic [1:0] t0_a_val, t0_b_val, t1_a_val, t1_b_val;
  logic [2:0] t0_a_str, t0_b_str, t1_a_str, t1_b_str;
  logic [1:0] t0_a_q_val, t0_b_q_val, t1_a_q_val, t1_b_q_val;
  logic [2:0] t0_a_q_str, t0_b_q_str, t1_a_q_str, t1_b_q_str;
  logic       t0_on, t1_on;

  int vectors;
  int miscompares;

  rtranif1_tranif0 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .t0_gate    (t0_gate),
    .t1_gate    (t1_gate),
    .t0_a_val   (t0_a_val),
    .t0_b_val   (t0_b_val),
    .t1_a_val   (t1_a_val),
    .t1_b_val   (t1_b_val),
    .t0_a_str   (t0_a_str),
    .t0_b_str   (t0_b_str),
    .t1_a_str   (t1_a_str),
    .t1_b_str   (t1_b_str),
    .t0_a_q_val (t0_a_q_val),
    .t0_b_q_val (t0_b_q_val),
    .t1_a_q_val (t1_a_q_val),
    .t1_b_q_val (t1_b_q_val),
    .t0_a_q_str (t0_a_q_str),
    .t0_b_q_str (t0_b_q_str),
    .t1_a_q_str (t1_a_q_str),
    .t1_b_q_str (t1_b_q_str),
    .t0_on      (t0_on),
    .t1_on      (t1_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one (value, strength) terminal result.
  task automatic chk_term(input string tag, input logic [1:0] ov, input logic [2:0] os,
                          input logic [1:0] ev, input logic [2:0] es);
    vectors++;
    assert ({ov, os} === {ev, es})
    else begin
      miscompares++;
      $error("FAIL %s observed=(%b,%0d) expected=(%b,%0d)", tag, ov, os, ev, es);
    end
  endtask

  task automatic chk_bit(input string tag, input logic o, input logic e);
    vectors++;
    assert (o === e)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Check every output of both channels.
  task automatic chk_all(input string tag,
                         input logic [1:0] e0av, input logic [2:0] e0as,
                         input logic [1:0] e0bv, input logic [2:0] e0bs, input logic e0on,
                         input logic [1:0] e1av, input logic [2:0] e1as,
                         input logic [1:0] e1bv, input logic [2:0] e1bs, input logic e1on);
    chk_term({tag, ".t0_a"}, t0_a_q_val, t0_a_q_str, e0av, e0as);
    chk_term({tag, ".t0_b"}, t0_b_q_val, t0_b_q_str, e0bv, e0bs);
    chk_bit ({tag, ".t0_on"}, t0_on, e0on);
    chk_term({tag, ".t1_a"}, t1_a_q_val, t1_a_q_str, e1av, e1as);
    chk_term({tag, ".t1_b"}, t1_b_q_val, t1_b_q_str, e1bv, e1bs);
    chk_bit ({tag, ".t1_on"}, t1_on, e1on);
    $display("step %-10s t0 a=(%b,%0d) b=(%b,%0d) on=%b | t1 a=(%b,%0d) b=(%b,%0d) on=%b",
             tag, t0_a_q_val, t0_a_q_str, t0_b_q_val, t0_b_q_str, t0_on,
             t1_a_q_val, t1_a_q_str, t1_b_q_val, t1_b_q_str, t1_on);
  endtask

  task automatic drive(input logic [1:0] g0, input logic [1:0] a0v, input logic [2:0] a0s,
                       input logic [1:0] b0v, input logic [2:0] b0s,
                       input logic [1:0] g1, input logic [1:0] a1v, input logic [2:0] a1s,
                       input logic [1:0] b1v, input logic [2:0] b1s);
    t0_gate = g0; t0_a_val = a0v; t0_a_str = a0s; t0_b_val = b0v; t0_b_str = b0s;
    t1_gate = g1; t1_a_val = a1v; t1_a_str = a1s; t1_b_val = b1v; t1_b_str = b1s;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    // Arbitrary, conducting inputs while in reset.
    drive(V0, V1, 3'd6, V0, 3'd7,  V1, V0, 3'd7, V1, 3'd5);

    #1 rst_n = 1'b0;
    #1;
    chk_all("reset_async", VZ,0, VZ,0, 1'b0,  VZ,0, VZ,0, 1'b0);
    step();
    chk_all("reset_held", VZ,0, VZ,0, 1'b0,  VZ,0, VZ,0, 1'b0);

    // 1: tranif0 pass; rtranif1 resistive contention. First edge after reset.
    rst_n = 1'b1;
    drive(V0, V1, 3'd6, VZ, 3'd0,  V1, V0, 3'd7, V1, 3'd5);
    step();
    chk_all("v1_pass", V1,6, V1,6, 1'b1,  V0,7, VX,5, 1'b1);

    // 2: tranif0 open; rtranif1 drives undriven b at reduced strength.
    drive(V1, V1, 3'd6, V0, 3'd3,  V1, V0, 3'd6, VZ, 3'd0);
    #1;
    // Inputs changed but no edge yet: outputs must still hold vector 1.
    chk_all("v2_hold", V1,6, V1,6, 1'b1,  V0,7, VX,5, 1'b1);
    step();
    chk_all("v2_open", V1,6, V0,3, 1'b0,  V0,6, V0,5, 1'b1);

    // 3: unknown gates (t0 Z, t1 X).
    drive(VZ, V0, 3'd4, V1, 3'd2,  VX, V1, 3'd6, V0, 3'd0);
    step();
    chk_all("v3_unk", V0,4, VX,4, 1'b0,  V1,6, VX,5, 1'b0);

    // 4: unknown t1 gate with agreeing values; X input through tranif0.
    drive(V0, VX, 3'd5, V0, 3'd5,  VZ, V1, 3'd6, V1, 3'd6);
    step();
    chk_all("v4_xin", VX,5, VX,5, 1'b1,  V1,6, V1,6, 1'b0);

    // 5: reduction 4->2 and 1->1; Z value with nonzero strength is undriven.
    drive(V0, V0, 3'd2, VZ, 3'd7,  V1, V1, 3'd4, V0, 3'd1);
    step();
    chk_all("v5_red", V0,2, V0,2, 1'b1,  V1,4, V1,2, 1'b1);

    // 6: strength-0 drives on t0; equal-strength agreeing values on t1.
    drive(V0, V1, 3'd0, V0, 3'd0,  V1, V1, 3'd3, V1, 3'd2);
    step();
    chk_all("v6_eq", VZ,0, VZ,0, 1'b1,  V1,3, V1,2, 1'b1);

    // 7: t0 X gate into undriven b; t1 open.
    drive(VX, V1, 3'd6, VZ, 3'd0,  V0, V1, 3'd7, VZ, 3'd0);
    step();
    chk_all("v7_mix", V1,6, VX,6, 1'b0,  V1,7, VZ,0, 1'b0);

    // 8: both conducting, then reset asserted between edges.
    drive(V0, V1, 3'd6, VZ, 3'd0,  V1, V0, 3'd7, VZ, 3'd0);
    step();
    chk_all("v8_on", V1,6, V1,6, 1'b1,  V0,7, V0,5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("v8_rst_mid", VZ,0, VZ,0, 1'b0,  VZ,0, VZ,0, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk_all("v8_rst_rel", VZ,0, VZ,0, 1'b0,  VZ,0, VZ,0, 1'b0);
    step();
    chk_all("v8_resume", V1,6, V1,6, 1'b1,  V0,7, V0,5, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
